weight_load_sequencer: RTL and testbench
========================================

# weight_load_sequencer

Streams the complete binary-network parameter set (conv1 kernels/offsets, conv2 kernels/offsets, FC offsets and FC binary weights) from a single valid/ready beat source into the accelerator's parameter memories. It generates the layer select, address, chunk index and write strobe for each one-cycle memory write. It raises `weights_loaded` once every memory is filled, and the image handshake is gated on that signal. It sits between the host/DMA stream and the top-level parameter write port.

## Interface
- `N_K1`, 90, conv1 5x5 kernels (5 in x 18 out)
- `N_O1`, 18, conv1 offsets
- `N_K2`, 1080, conv2 5x5 kernels (18 x 60)
- `N_O2`, 60, conv2 offsets
- `N_FC`, 10, FC output rows (offsets and binary rows)
- `FC_CHUNKS`, 48, 20-bit chunks per FC binary row (960/20)
- `clk`  in  1  clock; one clock
- `rst_n`  in  1  reset; synchronous, active-low
- `start`  in  1  pulse; begin a full load
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat ready
- `s_data`  in  25  beat payload
- `wr_valid`  out  1  parameter write strobe (one cycle per beat)
- `wr_layer`  out  2  1=conv1, 2=conv2, 3=fc
- `wr_kind`  out  1  0=kernel/binary row, 1=offset
- `wr_addr`  out  11  kernel/offset/row index
- `wr_chunk`  out  6  FC binary chunk index; 0 otherwise
- `wr_data`  out  25  masked payload
- `weights_loaded`  out  1  full set resident
- `load_done`  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, L1K, L1O, L2K, L2O, FCO, FCB, DONE.
- Beats and sections, in fixed order:
  - L1K: `N_K1` beats, layer 1, kind 0, `wr_data` = `s_data[24:0]`.
  - L1O: `N_O1` beats, layer 1, kind 1.
  - L2K: `N_K2` beats, layer 2, kind 0.
  - L2O: `N_O2` beats, layer 2, kind 1.
  - FCO: `N_FC` beats, layer 3, kind 1.
  - FCB: `N_FC*FC_CHUNKS` beats, layer 3, kind 0. Chunk is the inner index (0..47); the row index `wr_addr` is the outer index (0..9).
- Total beats per load: 1738.
- Data masking:
  - Offset beats: `wr_data` = {17'b0, `s_data[7:0]`}.
  - FCB beats: `wr_data` = {5'b0, `s_data[19:0]`}.
  - Kernel beats: all 25 bits pass through; bit 24-5r-c = kernel row r, column c.
- `wr_addr` counts from 0 within each section and resets to 0 on every section change.
- State transitions:
  - IDLE or DONE, `start`=1 → L1K. On the same edge, clear `weights_loaded` and all counters.
  - `start` while in a load state (L1K..FCB) is ignored.
  - Accepting the last beat of a section moves to the next section on the same edge.
  - Accepting the last FCB beat (row 9, chunk 47) → DONE.
- `s_ready` = 1 exactly in L1K..FCB; 0 in IDLE and DONE. It is registered from state and does not depend combinationally on `s_valid`.
- A beat is accepted when `s_valid & s_ready`. Idle cycles (`s_valid`=0) do not advance the counters.
- Reset mid-load: all outputs return to reset values and state returns to IDLE. Partially written memories are not cleared; `weights_loaded` stays 0 until a complete reload finishes.

## Timing
- Reset values: `s_ready`=0, `wr_valid`=0, `wr_layer`=0, `wr_kind`=0, `wr_addr`=0, `wr_chunk`=0, `wr_data`=0, `weights_loaded`=0, `load_done`=0.
- Write port outputs are registered. A beat accepted at edge N drives `wr_valid`=1 with its fields during cycle N+1. `wr_valid`=0 in any cycle following an edge with no accept.
- The memories write at the edge ending cycle N+1, giving one-cycle write latency.
- Throughput: one beat per cycle, no bubbles. A full load takes 1738 accepting cycles.
- Completion: `weights_loaded` and `load_done` assert in the same cycle as the `wr_valid` of the final FCB beat. `load_done` lasts one cycle; `weights_loaded` holds until the next `start` or reset.
- The first beat of a load can be accepted in the cycle after the `start` edge.

## Test plan
- Reset, then drive no stimulus for 5 cycles → all outputs 0, `s_ready`=0, state IDLE.
- `start` plus 1738 back-to-back beats with `s_data` = beat index:
  - beat 0 → layer 1, kind 0, addr 0.
  - beat 90 → layer 1, kind 1, addr 0, data 90&0xFF.
  - beat 108 → layer 2, kind 0, addr 0.
  - beat 1188 → layer 2, kind 1, addr 0.
  - beat 1248 → layer 3, kind 1, addr 0.
  - beat 1258 → layer 3, kind 0, addr 0, chunk 0.
  - beat 1737 → addr 9, chunk 47.
  - `load_done` pulses once; `weights_loaded`=1; `s_ready`=0.
- Random `s_valid` gaps (50% duty) → identical write sequence to the back-to-back case; `wr_valid` count = 1738; no write during gap cycles.
- Pulse `start` again at beat 500 of a load → ignored, sequence unchanged.
- After DONE, pulse `start` → `weights_loaded` drops the next cycle and the load restarts at L1K addr 0.
- Assert `rst_n`=0 at beat 1100 (inside L2K) → next cycle all outputs 0, state IDLE. A following `start` and full load completes normally.
- Kernel beat with `s_data`=25'h1FFFFFF in L1K → `wr_data`=25'h1FFFFFF. Same value on an offset beat → `wr_data`=25'h00000FF. On an FCB beat → 25'h00FFFFF.

Source files
------------

// File: rtl/weight_load_sequencer.sv
// Streams the full parameter set from one valid/ready source into layer memories.
// Latency: a beat accepted at edge N is written in cycle N+1. s_ready is held high only while a load is in progress.
module weight_load_sequencer #(
  parameter int N_K1      = 90,
  parameter int N_O1      = 18,
  parameter int N_K2      = 1080,
  parameter int N_O2      = 60,
  parameter int N_FC      = 10,
  parameter int FC_CHUNKS = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [24:0] s_data,
  output logic        wr_valid,
  output logic [1:0]  wr_layer,
  output logic        wr_kind,
  output logic [10:0] wr_addr,
  output logic [5:0]  wr_chunk,
  output logic [24:0] wr_data,
  output logic        weights_loaded,
  output logic        load_done
);

  typedef enum logic [2:0] {IDLE, L1K, L1O, L2K, L2O, FCO, FCB, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [5:0]  chunk_q, chunk_d;
  logic        s_ready_q, s_ready_d;
  logic        wr_valid_q, wr_valid_d;
  logic [1:0]  wr_layer_q, wr_layer_d;
  logic        wr_kind_q, wr_kind_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [5:0]  wr_chunk_q, wr_chunk_d;
  logic [24:0] wr_data_q, wr_data_d;
  logic        loaded_q, loaded_d;
  logic        load_done_q, load_done_d;

  logic        accept;
  logic        sec_last;
  state_t      sec_next;
  logic [24:0] off_data, fcb_data;

  assign accept   = s_valid & s_ready_q;
  assign off_data = {17'b0, s_data[7:0]};
  assign fcb_data = {5'b0, s_data[19:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    chunk_d     = chunk_q;
    wr_valid_d  = 1'b0;
    wr_layer_d  = wr_layer_q;
    wr_kind_d   = wr_kind_q;
    wr_addr_d   = wr_addr_q;
    wr_chunk_d  = wr_chunk_q;
    wr_data_d   = wr_data_q;
    loaded_d    = loaded_q;
    load_done_d = 1'b0;
    sec_last    = 1'b0;
    sec_next    = state_q;

    case (state_q)
      L1K: begin wr_layer_d = 2'd1; wr_kind_d = 1'b0; wr_data_d = s_data;
                 sec_last = (addr_q == 11'(N_K1 - 1)); sec_next = L1O; end
      L1O: begin wr_layer_d = 2'd1; wr_kind_d = 1'b1; wr_data_d = off_data;
                 sec_last = (addr_q == 11'(N_O1 - 1)); sec_next = L2K; end
      L2K: begin wr_layer_d = 2'd2; wr_kind_d = 1'b0; wr_data_d = s_data;
                 sec_last = (addr_q == 11'(N_K2 - 1)); sec_next = L2O; end
      L2O: begin wr_layer_d = 2'd2; wr_kind_d = 1'b1; wr_data_d = off_data;
                 sec_last = (addr_q == 11'(N_O2 - 1)); sec_next = FCO; end
      FCO: begin wr_layer_d = 2'd3; wr_kind_d = 1'b1; wr_data_d = off_data;
                 sec_last = (addr_q == 11'(N_FC - 1)); sec_next = FCB; end
      FCB: begin wr_layer_d = 2'd3; wr_kind_d = 1'b0; wr_data_d = fcb_data; end
      default: ;
    endcase

    if (state_q == IDLE || state_q == DONE) begin
      // Field registers keep stale values here; only wr_valid qualifies them.
      wr_layer_d = wr_layer_q;
      wr_kind_d  = wr_kind_q;
      wr_data_d  = wr_data_q;
      if (start) begin
        state_d  = L1K;
        addr_d   = '0;
        chunk_d  = '0;
        loaded_d = 1'b0;
      end
    end else if (!accept) begin
      wr_layer_d = wr_layer_q;
      wr_kind_d  = wr_kind_q;
      wr_data_d  = wr_data_q;
    end else begin
      wr_valid_d = 1'b1;
      wr_addr_d  = addr_q;
      wr_chunk_d = (state_q == FCB) ? chunk_q : 6'd0;
      if (state_q == FCB) begin
        // Chunk is the inner index, row (addr) the outer one.
        if (chunk_q == 6'(FC_CHUNKS - 1)) begin
          chunk_d = '0;
          if (addr_q == 11'(N_FC - 1)) begin
            state_d     = DONE;
            addr_d      = '0;
            loaded_d    = 1'b1;
            load_done_d = 1'b1;
          end else begin
            addr_d = addr_q + 11'd1;
          end
        end else begin
          chunk_d = chunk_q + 6'd1;
        end
      end else if (sec_last) begin
        state_d = sec_next;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + 11'd1;
      end
    end

    s_ready_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      chunk_q     <= '0;
      s_ready_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_layer_q  <= '0;
      wr_kind_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_chunk_q  <= '0;
      wr_data_q   <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      chunk_q     <= chunk_d;
      s_ready_q   <= s_ready_d;
      wr_valid_q  <= wr_valid_d;
      wr_layer_q  <= wr_layer_d;
      wr_kind_q   <= wr_kind_d;
      wr_addr_q   <= wr_addr_d;
      wr_chunk_q  <= wr_chunk_d;
      wr_data_q   <= wr_data_d;
      loaded_q    <= loaded_d;
      load_done_q <= load_done_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign wr_valid       = wr_valid_q;
  assign wr_layer       = wr_layer_q;
  assign wr_kind        = wr_kind_q;
  assign wr_addr        = wr_addr_q;
  assign wr_chunk       = wr_chunk_q;
  assign wr_data        = wr_data_q;
  assign weights_loaded = loaded_q;
  assign load_done      = load_done_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Scoreboard bench for weight_load_sequencer: expected writes are queued at accept time and matched on wr_valid.
module tb_weight_load_sequencer;

  localparam int TOTAL  = 1738;
  localparam int BUDGET = 8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_data = '0;
  logic        wr_valid;
  logic [1:0]  wr_layer;
  logic        wr_kind;
  logic [10:0] wr_addr;
  logic [5:0]  wr_chunk;
  logic [24:0] wr_data;
  logic        weights_loaded;
  logic        load_done;

  always #5 clk = ~clk;

  weight_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_valid(wr_valid), .wr_layer(wr_layer), .wr_kind(wr_kind),
    .wr_addr(wr_addr), .wr_chunk(wr_chunk), .wr_data(wr_data),
    .weights_loaded(weights_loaded), .load_done(load_done)
  );

  typedef struct packed {
    logic [1:0]  layer;
    logic        kind;
    logic [10:0] addr;
    logic [5:0]  chunk;
    logic [24:0] data;
    logic        last;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  n_wr = 0;
  int  n_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference mapping from absolute beat index to the write it must produce.
  function automatic wr_t model(input int k, input logic [24:0] d);
    wr_t e;
    int  j;
    e.chunk = '0;
    e.last  = (k == TOTAL - 1);
    if (k < 90) begin
      e.layer = 2'd1; e.kind = 1'b0; e.addr = 11'(k);        e.data = d;
    end else if (k < 108) begin
      e.layer = 2'd1; e.kind = 1'b1; e.addr = 11'(k - 90);   e.data = {17'b0, d[7:0]};
    end else if (k < 1188) begin
      e.layer = 2'd2; e.kind = 1'b0; e.addr = 11'(k - 108);  e.data = d;
    end else if (k < 1248) begin
      e.layer = 2'd2; e.kind = 1'b1; e.addr = 11'(k - 1188); e.data = {17'b0, d[7:0]};
    end else if (k < 1258) begin
      e.layer = 2'd3; e.kind = 1'b1; e.addr = 11'(k - 1248); e.data = {17'b0, d[7:0]};
    end else begin
      j = k - 1258;
      e.layer = 2'd3; e.kind = 1'b0; e.addr = 11'(j / 48); e.chunk = 6'(j % 48);
      e.data = {5'b0, d[19:0]};
    end
    return e;
  endfunction

  function automatic logic [24:0] pattern(input int k, input bit ones);
    if (!ones) return 25'(k);
    if (k == 0 || k == 90 || k == 1258 || k == 1100 || k == 1250) return 25'h1FFFFFF;
    return 25'($urandom);
  endfunction

  task automatic monitor();
    wr_t e;
    if (wr_valid) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("spurious_wr", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_fields", 64'({wr_layer, wr_kind, wr_addr, wr_chunk, wr_data}),
              64'({e.layer, e.kind, e.addr, e.chunk, e.data}));
        check("done_flags", 64'({load_done, weights_loaded}), 64'({e.last, e.last}));
      end
    end else begin
      check("done_no_wr", 64'(load_done), 64'd0);
    end
    if (load_done) n_done++;
  endtask

  // Called at a negedge: drive inputs, queue the beat if it will be accepted, then advance one cycle.
  task automatic step(input logic v, input logic [24:0] d, input logic st, input int k, output bit acc);
    s_valid = v;
    s_data  = d;
    start   = st;
    acc     = v && s_ready && rst_n;
    if (acc) sb.push_back(model(k, d));
    @(negedge clk);
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({s_ready, wr_valid, wr_layer, wr_kind, wr_addr, wr_chunk, wr_data,
                    weights_loaded, load_done}), 64'd0);
  endtask

  task automatic run_load(input bit gaps, input int start_at, input int rst_at, input bit ones);
    int          k;
    int          cyc;
    bit          acc;
    bit          pulsed;
    logic        v;
    logic [24:0] d;
    k = 0; cyc = 0; pulsed = 1'b0;
    n_wr = 0; n_done = 0;
    step(1'b0, '0, 1'b1, 0, acc);
    check("loaded_clr", 64'(weights_loaded), 64'd0);
    check("ready_up", 64'(s_ready), 64'd1);
    while (k < TOTAL && cyc < BUDGET) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0, k, acc);
        check_all_zero("rst_mid_outs");
        check("rst_sb_empty", 64'(sb.size()), 64'd0);
        rst_n = 1'b1;
        sb.delete();
        step(1'b1, 25'h5, 1'b0, 0, acc);
        check("rst_idle_no_wr", 64'(wr_valid), 64'd0);
        return;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = pattern(k, ones);
      step(v, d, (k == start_at) && !pulsed, k, acc);
      if (k == start_at) pulsed = 1'b1;
      if (acc) k++;
      cyc++;
    end
    check("load_timeout", 64'(cyc < BUDGET), 64'd1);
    repeat (3) step(1'b1, '0, 1'b0, 0, acc);
    check("wr_count", 64'(n_wr), 64'(TOTAL));
    check("done_count", 64'(n_done), 64'd1);
    check("loaded_hold", 64'(weights_loaded), 64'd1);
    check("ready_done", 64'(s_ready), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    s_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 0, acc);
      check_all_zero("reset_idle");
    end
    run_load(1'b0, -1, -1, 1'b0);
    run_load(1'b1, 500, -1, 1'b0);
    run_load(1'b0, -1, 1100, 1'b0);
    check("loaded_after_rst", 64'(weights_loaded), 64'd0);
    run_load(1'b1, -1, -1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
